// File: rtl/hier_rx_pkg.sv
// Shared types and helpers for the hierarchical inverter-chain frame receiver.
package hier_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic IDLE_LVL = 1'b1;

    // Parity bit that makes the total count of ones (word + bit) even.
    function automatic logic even_par(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/hier_rx_obuf.sv
// One-entry valid/ready output buffer: a commit into a full, unaccepted entry
// is dropped and flagged with a one-cycle overrun pulse.
module hier_rx_obuf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (commit_i) begin
            // An accept in the same cycle frees the slot for the new word.
            if (!valid_q || ready_i) begin
                data_d  = wdata_i;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/hier_chain_rx.sv
// Serial frame receiver at the end of the inverter chain: start, DATA_W bits
// LSB first, optional even parity (HIER_RX_PARITY_EN), stop; one bit per clock.
module hier_chain_rx
    import hier_rx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter bit INVERT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              overrun,
    output logic              frm_err
`ifdef HIER_RX_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              lb_q;
    logic              frm_err_q, frm_err_d;
    logic              commit;
`ifdef HIER_RX_PARITY_EN
    logic              par_q, par_d;
    logic              par_err_q, par_err_d;
    logic              par_bad;

    assign par_bad = (even_par(32'(shreg_q)) != par_q);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        frm_err_d = 1'b0;
        commit    = 1'b0;
`ifdef HIER_RX_PARITY_EN
        par_d     = par_q;
        par_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (lb_q == 1'b0) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                shreg_d[cnt_q] = lb_q;
                if (cnt_q == CW'(DATA_W - 1)) begin
`ifdef HIER_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef HIER_RX_PARITY_EN
            PARITY: begin
                par_d   = lb_q;
                state_d = STOP;
            end
`endif
            STOP: begin
                // A bad stop bit masks any parity error on the same frame.
                if (lb_q == IDLE_LVL) begin
                    state_d = IDLE;
`ifdef HIER_RX_PARITY_EN
                    if (par_bad) par_err_d = 1'b1;
                    else         commit    = 1'b1;
`else
                    commit  = 1'b1;
`endif
                end else begin
                    frm_err_d = 1'b1;
                    state_d   = BREAK;
                end
            end
            BREAK: begin
                if (lb_q == IDLE_LVL) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lb_q      <= IDLE_LVL;
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            frm_err_q <= 1'b0;
`ifdef HIER_RX_PARITY_EN
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            lb_q      <= in ^ INVERT;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            frm_err_q <= frm_err_d;
`ifdef HIER_RX_PARITY_EN
            par_q     <= par_d;
            par_err_q <= par_err_d;
`endif
        end
    end

    hier_rx_obuf #(.DATA_W(DATA_W)) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .commit_i  (commit),
        .wdata_i   (shreg_q),
        .ready_i   (ready),
        .data_o    (data),
        .valid_o   (valid),
        .overrun_o (overrun)
    );

    assign frm_err = frm_err_q;
`ifdef HIER_RX_PARITY_EN
    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_hier_chain_rx.sv
// Randomized and directed bench for hier_chain_rx (DATA_W=8, INVERT=1);
// honours HIER_RX_PARITY_EN when it is defined for the build.
module tb_hier_chain_rx;

    localparam int EV_NONE = 0;
    localparam int EV_GOOD = 1;
    localparam int EV_FRM  = 2;
    localparam int EV_PAR  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       overrun;
    logic       frm_err;
`ifdef HIER_RX_PARITY_EN
    logic       par_err;
`endif

    int checks = 0;
    int errors = 0;
    int stepn  = 0;

    // Reference model: the buffer is a capacity-one queue of words; the frame
    // outcome of a stop bit driven on `in` shows up one step later.
    logic [7:0] mq[$];
    logic [7:0] exp_data;
    int         due_evt;
    logic [7:0] due_w;

    always #5 clk = ~clk;

    hier_chain_rx #(.DATA_W(8), .INVERT(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .overrun (overrun),
        .frm_err (frm_err)
`ifdef HIER_RX_PARITY_EN
        ,
        .par_err (par_err)
`endif
    );

    // Drive one line bit (raw in = complement) and compare against the model.
    task automatic step(input bit line, input bit rdy, input int evt,
                        input logic [7:0] w, input string tag);
        bit e_ovr, e_frm, e_par;
        @(negedge clk);
        rst   = 1'b0;
        in    = ~line;
        ready = rdy;
        e_ovr = 1'b0;
        e_frm = (due_evt == EV_FRM);
        e_par = (due_evt == EV_PAR);
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (due_evt == EV_GOOD) begin
            if (mq.size() > 0) e_ovr = 1'b1;
            else begin
                mq.push_back(due_w);
                exp_data = due_w;
            end
        end
        @(posedge clk);
        #1;
        stepn++;
        checks++;
        if (valid !== (mq.size() > 0)) begin
            errors++;
            $display("FAIL %s valid step %0d: got %0b want %0b", tag, stepn, valid, mq.size() > 0);
        end
        checks++;
        if (data !== exp_data) begin
            errors++;
            $display("FAIL %s data step %0d: got %h want %h", tag, stepn, data, exp_data);
        end
        checks++;
        if (overrun !== e_ovr) begin
            errors++;
            $display("FAIL %s overrun step %0d: got %0b want %0b", tag, stepn, overrun, e_ovr);
        end
        checks++;
        if (frm_err !== e_frm) begin
            errors++;
            $display("FAIL %s frm_err step %0d: got %0b want %0b", tag, stepn, frm_err, e_frm);
        end
`ifdef HIER_RX_PARITY_EN
        checks++;
        if (par_err !== e_par) begin
            errors++;
            $display("FAIL %s par_err step %0d: got %0b want %0b", tag, stepn, par_err, e_par);
        end
`endif
        due_evt = evt;
        due_w   = w;
    endtask

    task automatic send_frame(input logic [7:0] w, input bit stop, input bit pflip,
                              input bit rdy, input string tag);
        int ev;
        step(1'b0, rdy, EV_NONE, 8'h00, tag);
        for (int k = 0; k < 8; k++) step(w[k], rdy, EV_NONE, 8'h00, tag);
`ifdef HIER_RX_PARITY_EN
        step((^w) ^ pflip, rdy, EV_NONE, 8'h00, tag);
        ev = !stop ? EV_FRM : (pflip ? EV_PAR : EV_GOOD);
`else
        ev = (!stop || pflip && 1'b0) ? EV_FRM : EV_GOOD;
`endif
        step(stop, rdy, ev, w, tag);
    endtask

    task automatic test_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst   = 1'b1;
            ready = 1'(($urandom_range(0, 1)));
            mq.delete();
            exp_data = 8'h00;
            due_evt  = EV_NONE;
            @(posedge clk);
            #1;
            checks++;
            if ({valid, overrun, frm_err} !== 3'b000 || data !== 8'h00) begin
                errors++;
                $display("FAIL reset outputs: got valid=%0b ovr=%0b frm=%0b data=%h want all 0",
                         valid, overrun, frm_err, data);
            end
`ifdef HIER_RX_PARITY_EN
            checks++;
            if (par_err !== 1'b0) begin
                errors++;
                $display("FAIL reset par_err: got %0b want 0", par_err);
            end
`endif
        end
    endtask

    task automatic test_good;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, "good");
        step(1'b1, 1'b1, EV_NONE, 8'h00, "good");
        checks++;
        if (valid !== 1'b1 || data !== 8'hA5) begin
            errors++;
            $display("FAIL good_a5: got valid=%0b data=%h want 1/a5", valid, data);
        end
        step(1'b1, 1'b1, EV_NONE, 8'h00, "good");
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL good_one_cycle: got valid=%0b want 0", valid);
        end
    endtask

    task automatic test_back_to_back;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, "b2b");
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, "b2b");
        step(1'b1, 1'b0, EV_NONE, 8'h00, "b2b");
        checks++;
        if (overrun !== 1'b1 || data !== 8'h3C || valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_overrun: got ovr=%0b data=%h valid=%0b want 1/3c/1", overrun, data, valid);
        end
        step(1'b1, 1'b1, EV_NONE, 8'h00, "b2b");
        checks++;
        if (valid !== 1'b0 || data !== 8'h3C || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got valid=%0b data=%h ovr=%0b want 0/3c/0", valid, data, overrun);
        end
    endtask

    task automatic test_commit_accept;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, "cmacc");
        step(1'b1, 1'b0, EV_NONE, 8'h00, "cmacc");
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, "cmacc");
        step(1'b1, 1'b1, EV_NONE, 8'h00, "cmacc");
        checks++;
        if (valid !== 1'b1 || data !== 8'hC3 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL commit_accept: got valid=%0b data=%h ovr=%0b want 1/c3/0", valid, data, overrun);
        end
        step(1'b1, 1'b1, EV_NONE, 8'h00, "cmacc");
    endtask

    task automatic test_frame_err;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, "frm");
        step(1'b0, 1'b1, EV_NONE, 8'h00, "frm");
        checks++;
        if (frm_err !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL frm_pulse: got frm=%0b valid=%0b want 1/0", frm_err, valid);
        end
        for (int i = 0; i < 19; i++) step(1'b0, 1'b1, EV_NONE, 8'h00, "frm_break");
        step(1'b1, 1'b1, EV_NONE, 8'h00, "frm");
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, "frm_next");
        step(1'b1, 1'b1, EV_NONE, 8'h00, "frm_next");
        checks++;
        if (valid !== 1'b1 || data !== 8'h0F) begin
            errors++;
            $display("FAIL frm_recover: got valid=%0b data=%h want 1/0f", valid, data);
        end
        step(1'b1, 1'b1, EV_NONE, 8'h00, "frm_next");
    endtask

    task automatic test_parity;
`ifdef HIER_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1, 1'b1, "par");
        step(1'b1, 1'b1, EV_NONE, 8'h00, "par");
        checks++;
        if (par_err !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL par_err: got par=%0b valid=%0b want 1/0", par_err, valid);
        end
`else
        send_frame(8'h01, 1'b1, 1'b0, 1'b1, "par");
        step(1'b1, 1'b1, EV_NONE, 8'h00, "par");
        checks++;
        if (valid !== 1'b1 || data !== 8'h01) begin
            errors++;
            $display("FAIL nopar_01: got valid=%0b data=%h want 1/01", valid, data);
        end
`endif
        step(1'b1, 1'b1, EV_NONE, 8'h00, "par");
    endtask

    task automatic test_mid_reset;
        step(1'b0, 1'b1, EV_NONE, 8'h00, "midrst");
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, EV_NONE, 8'h00, "midrst");
        test_reset(1);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, EV_NONE, 8'h00, "midrst");
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, "midrst");
        step(1'b1, 1'b0, EV_NONE, 8'h00, "midrst");
        checks++;
        if (valid !== 1'b1 || data !== 8'h81) begin
            errors++;
            $display("FAIL midrst_81: got valid=%0b data=%h want 1/81", valid, data);
        end
        step(1'b1, 1'b1, EV_NONE, 8'h00, "midrst");
    endtask

    task automatic test_random(input int n);
        logic [7:0] w;
        bit         stop, pf, r;
        for (int i = 0; i < n; i++) begin
            w    = 8'($urandom);
            r    = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 5) != 0);
            pf   = ($urandom_range(0, 4) == 0);
            send_frame(w, stop, pf, r, "rand");
            if (!stop) begin
                for (int g = 0; g < int'($urandom_range(0, 3)); g++)
                    step(1'b0, 1'($urandom_range(0, 1)), EV_NONE, 8'h00, "rand");
                step(1'b1, 1'($urandom_range(0, 1)), EV_NONE, 8'h00, "rand");
            end else begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                    step(1'b1, 1'($urandom_range(0, 1)), EV_NONE, 8'h00, "rand");
            end
        end
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, EV_NONE, 8'h00, "rand");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in       = 1'b0;
        ready    = 1'b0;
        due_evt  = EV_NONE;
        due_w    = 8'h00;
        exp_data = 8'h00;
        test_reset(3);
        test_good();
        test_back_to_back();
        test_commit_accept();
        test_frame_err();
        test_parity();
        test_mid_reset();
        test_random(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
